// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point field widths and the alignment FSM state type.
// Word layout is {sign, exp[EXP_W-1:0], mantis[MANT_W-1:0]} with an explicit
// leading one at mantis[MANT_W-1] (no hidden bit). normalize_fp uses the same widths.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned WIDTH  = 1 + EXP_W + MANT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/align_fp.sv
// align_fp: right-shift alignment of a float operand to a target exponent.
// Shifts the mantissa right one bit per clock while incrementing the exponent,
// collecting guard and sticky bits for the downstream adder's rounding.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-high
//   en          in   load/start strobe; aborts and restarts any operation in flight
//   number      in   operand {sign, exp, mantis}
//   target_exp  in   exponent to align to (unsigned)
//   out         out  aligned operand {sign, exp_r, mant_r}
//   guard       out  last bit shifted out of the mantissa
//   sticky      out  OR of every bit shifted out before guard
//   busy        out  high while shifting
//   ready       out  result valid; holds until the next en or rst
//   bad_target  out  target_exp was below the operand exponent; out = number
module align_fp
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned MANT_W = fp_pkg::MANT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [EXP_W+MANT_W:0]     number,
  input  logic [EXP_W-1:0]          target_exp,
  output logic [EXP_W+MANT_W:0]     out,
  output logic                      guard,
  output logic                      sticky,
  output logic                      busy,
  output logic                      ready,
  output logic                      bad_target
);

  localparam int unsigned W = 1 + EXP_W + MANT_W;

  // Largest distance still handled by shifting; anything beyond flushes.
  localparam logic [EXP_W:0] MaxShift = (EXP_W + 1)'(MANT_W + 1);

  state_t              r_state;
  logic                r_sign;
  logic [EXP_W-1:0]    r_exp;
  logic [MANT_W-1:0]   r_mant;
  logic [EXP_W-1:0]    r_target;
  logic                r_guard;
  logic                r_sticky;
  logic                r_busy;
  logic                r_ready;
  logic                r_bad;
  logic                r_bad_pend;

  logic                w_sign_in;
  logic [EXP_W-1:0]    w_exp_in;
  logic [MANT_W-1:0]   w_mant_in;
  logic [EXP_W:0]      w_d;
  logic                w_neg;
  logic                w_zero_d;
  logic                w_flush;
  logic [EXP_W-1:0]    w_exp_inc;

  assign w_sign_in = number[W-1];
  assign w_exp_in  = number[W-2:MANT_W];
  assign w_mant_in = number[MANT_W-1:0];

  // EXP_W+1-bit two's complement difference; the top bit is the sign.
  assign w_d      = {1'b0, target_exp} - {1'b0, w_exp_in};
  assign w_neg    = w_d[EXP_W];
  assign w_zero_d = (w_d == '0);
  assign w_flush  = !w_neg && (w_d > MaxShift);

  assign w_exp_inc = r_exp + EXP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_target   <= '0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_bad      <= 1'b0;
      r_bad_pend <= 1'b0;
    end else if (en) begin
      r_sign     <= w_sign_in;
      r_exp      <= w_exp_in;
      r_mant     <= w_mant_in;
      r_target   <= target_exp;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_ready    <= 1'b0;
      r_bad      <= 1'b0;
      r_bad_pend <= 1'b0;
      r_busy     <= 1'b0;
      if (w_neg) begin
        r_bad_pend <= 1'b1;
        r_state    <= DONE;
      end else if (w_zero_d) begin
        r_state <= DONE;
      end else if (w_mant_in == '0) begin
        r_exp   <= target_exp;
        r_state <= DONE;
      end else if (w_flush) begin
        r_mant   <= '0;
        r_exp    <= target_exp;
        r_sticky <= |w_mant_in;
        r_state  <= DONE;
      end else begin
        r_busy  <= 1'b1;
        r_state <= SHIFT;
      end
    end else begin
      unique case (r_state)
        SHIFT: begin
          r_mant   <= r_mant >> 1;
          r_exp    <= w_exp_inc;
          r_guard  <= r_mant[0];
          r_sticky <= r_sticky | r_guard;
          if (w_exp_inc == r_target) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Immediate-result loads enter DONE with ready low; it rises one edge later.
          if (!r_ready) begin
            r_ready <= 1'b1;
            r_bad   <= r_bad_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign out        = {r_sign, r_exp, r_mant};
  assign guard      = r_guard;
  assign sticky     = r_sticky;
  assign busy       = r_busy;
  assign ready      = r_ready;
  assign bad_target = r_bad;

endmodule

// File: tb/tb_align_fp.sv
module tb_align_fp;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] number;
  logic [7:0]  target_exp;
  logic [31:0] dut_out;
  logic        guard;
  logic        sticky;
  logic        busy;
  logic        ready;
  logic        bad_target;

  int checks   = 0;
  int failures = 0;

  align_fp dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .number     (number),
    .target_exp (target_exp),
    .out        (dut_out),
    .guard      (guard),
    .sticky     (sticky),
    .busy       (busy),
    .ready      (ready),
    .bad_target (bad_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result computed directly from the alignment rules.
  task automatic model(input logic [31:0] n, input logic [7:0] t, output logic [31:0] eo,
                       output logic eg, output logic es, output logic eb, output int lat,
                       output logic shifting);
    logic        s;
    int          e;
    int          d;
    longint      m;
    s = n[31];
    e = int'(n[30:23]);
    m = longint'(n[22:0]);
    eo = n; eg = 1'b0; es = 1'b0; eb = 1'b0; lat = 1; shifting = 1'b0;
    if (int'(t) < e) begin
      eb = 1'b1;
    end else if (int'(t) == e) begin
      // unchanged
    end else if (m == 0) begin
      eo = {s, t, 23'd0};
    end else begin
      d = int'(t) - e;
      if (d > 24) begin
        eo = {s, t, 23'd0};
        es = 1'b1;
      end else begin
        lat      = d;
        shifting = 1'b1;
        eo       = {s, t, 23'(m >> d)};
        eg       = ((m >> (d - 1)) & 64'd1) != 0;
        es       = (m & ((64'd1 << (d - 1)) - 1)) != 0;
      end
    end
  endtask

  // Drives en for exactly one rising edge (edge k); returns #1 after edge k.
  task automatic apply(input logic [31:0] n, input logic [7:0] t);
    @(negedge clk);
    number     = n;
    target_exp = t;
    en         = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // Checks busy after the load edge, ready latency, the result, and that it holds.
  task automatic measure(input string name, input logic [31:0] n, input logic [7:0] t);
    logic [31:0] eo;
    logic        eg, es, eb, sh;
    int          lat;
    int          cyc;
    model(n, t, eo, eg, es, eb, lat, sh);
    checks++;
    if (busy !== sh) begin
      failures++;
      $display("FAIL %s busy_after_load got=%b exp=%b", name, busy, sh);
    end
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== lat) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", name, cyc, lat);
    end
    checks++;
    if ({dut_out, guard, sticky, bad_target, busy} !== {eo, eg, es, eb, 1'b0}) begin
      failures++;
      $display("FAIL %s result got out=%h g=%b s=%b bad=%b busy=%b exp out=%h g=%b s=%b bad=%b busy=0",
               name, dut_out, guard, sticky, bad_target, busy, eo, eg, es, eb);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ready, dut_out, guard, sticky, bad_target} !== {1'b1, eo, eg, es, eb}) begin
      failures++;
      $display("FAIL %s hold got rdy=%b out=%h g=%b s=%b bad=%b exp out=%h g=%b s=%b bad=%b",
               name, ready, dut_out, guard, sticky, bad_target, eo, eg, es, eb);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] n, input logic [7:0] t);
    apply(n, t);
    measure(name, n, t);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; number = '0; target_exp = '0;
    #12;
    checks++;
    if ({dut_out, guard, sticky, busy, ready, bad_target} !== 37'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {dut_out, guard, sticky, busy, ready, bad_target});
    end
    @(negedge clk);
    rst = 1'b0;
    number = 32'hFFFF_FFFF; target_exp = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dut_out, guard, sticky, busy, ready, bad_target} !== 37'd0) begin
      failures++;
      $display("FAIL idle_hold got=%h exp=0", {dut_out, guard, sticky, busy, ready, bad_target});
    end
  endtask

  task automatic test_directed();
    run_op("basic_shift", {1'b0, 8'h7F, 23'h400000}, 8'h81);
    run_op("guard_sticky", {1'b0, 8'h10, 23'h400003}, 8'h12);
    run_op("flush", {1'b1, 8'h10, 23'h400001}, 8'h74);
    run_op("bad_target", {1'b1, 8'h80, 23'h5A5A5A}, 8'h7E);
    run_op("d_zero", {1'b0, 8'h80, 23'h5A5A5A}, 8'h80);
    run_op("zero_mant", {1'b1, 8'h20, 23'h000000}, 8'h30);
    run_op("d_max", {1'b0, 8'h10, 23'h7FFFFF}, 8'h28);
    run_op("d_max_plus1", {1'b0, 8'h10, 23'h7FFFFF}, 8'h29);
    run_op("d_one", {1'b1, 8'hFE, 23'h400001}, 8'hFF);
  endtask

  task automatic test_restart();
    apply({1'b0, 8'h10, 23'h4ABCDE}, 8'h1A);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL restart_pre edge=%0d ready got=%b exp=0", i, ready);
      end
    end
    run_op("restart_new", {1'b1, 8'h40, 23'h612345}, 8'h45);
    // Restart out of DONE after a bad target must clear bad_target.
    run_op("restart_bad", {1'b0, 8'h90, 23'h400000}, 8'h10);
    run_op("restart_after_bad", {1'b0, 8'h10, 23'h400001}, 8'h13);
  endtask

  task automatic test_rst_mid_shift();
    apply({1'b0, 8'h10, 23'h4ABCDE}, 8'h1A);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dut_out, guard, sticky, busy, ready, bad_target} !== 37'd0) begin
      failures++;
      $display("FAIL rst_mid_shift got=%h exp=0", {dut_out, guard, sticky, busy, ready, bad_target});
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", {1'b0, 8'h7F, 23'h400000}, 8'h81);
  endtask

  task automatic test_back_to_back();
    // Second load lands on the edge right after the first (abort during SHIFT).
    apply({1'b0, 8'h01, 23'h7FFFFF}, 8'h15);
    run_op("b2b_second", {1'b1, 8'h33, 23'h4F0F0F}, 8'h3B);
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [7:0]  t;
    int          e;
    int          tt;
    for (int i = 0; i < 150; i++) begin
      n = $urandom;
      if ($urandom_range(0, 9) == 0) n[22:0] = '0;
      e = int'(n[30:23]);
      if ($urandom_range(0, 9) < 7) begin
        tt = e + int'($urandom_range(0, 26));
        if (tt > 255) tt = 255;
        t = 8'(tt);
      end else begin
        t = 8'($urandom);
      end
      run_op("random", n, t);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_rst_mid_shift();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
